// File: rtl/i2c_infc.sv
// i2c_infc: single-master I2C register-access engine.
//
// Runs one register write or one register read per i2c_enb_ip pulse against a
// fixed 7-bit slave address. The bus is timed in quarter-bit slots of QTR_DIV
// clk_ip cycles; SCL high and low phases are each two quarters.
//
// Ports
//   clk_ip            system clock, rising edge
//   rst_ip            asynchronous active-high reset
//   i2c_enb_ip        one-cycle start pulse (accepted only while idle)
//   i2c_rw_ip         1 = register read, 0 = register write
//   i2c_reg_adr_ip    target register address
//   i2c_wdata_ip      write data
//   i2c_rd_data_op    last byte successfully read from the slave
//   scl_op            open-drain SCL (0 or Z)
//   sda_io            open-drain SDA (0 or Z), sampled for ACK and read data
//   i2c_tx_active_op  high while a transaction is in progress
module i2c_infc #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         QTR_DIV    = 250
) (
  input  logic       clk_ip,
  input  logic       rst_ip,
  input  logic       i2c_enb_ip,
  input  logic       i2c_rw_ip,
  input  logic [7:0] i2c_reg_adr_ip,
  input  logic [7:0] i2c_wdata_ip,
  output logic [7:0] i2c_rd_data_op,
  output wire        scl_op,
  inout  wire        sda_io,
  output logic       i2c_tx_active_op
);

  localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_NACK, STOP
  } state_t;

  state_t       state, state_nx;
  logic [QW-1:0] qcnt;
  logic [1:0]   qtr;
  logic [2:0]   bit_cnt;
  logic [1:0]   byte_idx;     // 0: addr+W, 1: reg addr, 2: wdata or addr+R
  logic         rw_q;
  logic [7:0]   adr_q, wdata_q;
  logic [7:0]   tx_byte, rx_sh;
  logic         ack_smp;      // sampled SDA in the ACK slot, 1 = NACK
  logic         scl_low, sda_low, scl_low_q, sda_low_q;
  logic         qtr_end, bit_done, st_done, bit_edge, smp_pt;

  assign qtr_end  = (qcnt == QW'(QTR_DIV - 1));
  assign bit_done = qtr_end && (qtr == 2'd3);
  // START and STOP are three quarters long; the bit-shaped states are four.
  assign st_done  = qtr_end && (qtr == 2'd2);
  assign smp_pt   = qtr_end && (qtr == 2'd2);
  assign bit_edge = (qtr == 2'd0) || (qtr == 2'd3);

  always_comb begin
    tx_byte = {SLAVE_ADDR, 1'b0};
    case (byte_idx)
      2'd1:    tx_byte = adr_q;
      2'd2:    tx_byte = rw_q ? {SLAVE_ADDR, 1'b1} : wdata_q;
      default: tx_byte = {SLAVE_ADDR, 1'b0};
    endcase
  end

  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus raw line requests; lines are registered below so the
  // pads never see decode glitches.
  always_comb begin
    state_nx = state;
    scl_low  = 1'b0;
    sda_low  = 1'b0;
    case (state)
      IDLE: if (i2c_enb_ip) state_nx = START;
      START: begin
        sda_low = 1'b1;
        scl_low = (qtr == 2'd2);
        if (st_done) state_nx = SEND_BYTE;
      end
      SEND_BYTE: begin
        scl_low = bit_edge;
        sda_low = ~tx_byte[3'd7 - bit_cnt];
        if (bit_done && bit_cnt == 3'd7) state_nx = GET_ACK;
      end
      GET_ACK: begin
        scl_low = bit_edge;
        if (bit_done) begin
          if (ack_smp) state_nx = STOP;
          else begin
            case (byte_idx)
              2'd0:    state_nx = SEND_BYTE;
              2'd1:    state_nx = rw_q ? RSTART : SEND_BYTE;
              2'd2:    state_nx = rw_q ? RECV_BYTE : STOP;
              default: state_nx = STOP;
            endcase
          end
        end
      end
      RSTART: begin
        // q0 release SDA (SCL low), q1 release SCL, q2 SDA low, q3 SCL low
        scl_low = bit_edge;
        sda_low = qtr[1];
        if (bit_done) state_nx = SEND_BYTE;
      end
      RECV_BYTE: begin
        scl_low = bit_edge;
        if (bit_done && bit_cnt == 3'd7) state_nx = SEND_NACK;
      end
      SEND_NACK: begin
        scl_low = bit_edge;
        if (bit_done) state_nx = STOP;
      end
      STOP: begin
        // SDA rises when IDLE releases it, with SCL already high
        sda_low = 1'b1;
        scl_low = (qtr == 2'd0);
        if (st_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      qcnt           <= '0;
      qtr            <= 2'd0;
      bit_cnt        <= 3'd0;
      byte_idx       <= 2'd0;
      rw_q           <= 1'b0;
      adr_q          <= 8'h00;
      wdata_q        <= 8'h00;
      rx_sh          <= 8'h00;
      ack_smp        <= 1'b0;
      i2c_rd_data_op <= 8'h00;
      scl_low_q      <= 1'b0;
      sda_low_q      <= 1'b0;
    end else begin
      scl_low_q <= scl_low;
      sda_low_q <= sda_low;
      if (state == IDLE) begin
        qcnt     <= '0;
        qtr      <= 2'd0;
        bit_cnt  <= 3'd0;
        byte_idx <= 2'd0;
        if (i2c_enb_ip) begin
          rw_q    <= i2c_rw_ip;
          adr_q   <= i2c_reg_adr_ip;
          wdata_q <= i2c_wdata_ip;
        end
      end else if (state_nx != state) begin
        qcnt    <= '0;
        qtr     <= 2'd0;
        bit_cnt <= 3'd0;
        if (state == GET_ACK) byte_idx <= byte_idx + 2'd1;
      end else if (qtr_end) begin
        qcnt <= '0;
        qtr  <= qtr + 2'd1;
        if (qtr == 2'd3 && (state == SEND_BYTE || state == RECV_BYTE))
          bit_cnt <= bit_cnt + 3'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
      if (smp_pt && state == GET_ACK)   ack_smp <= sda_io;
      if (smp_pt && state == RECV_BYTE) rx_sh   <= {rx_sh[6:0], sda_io};
      if (state == RECV_BYTE && state_nx == SEND_NACK) i2c_rd_data_op <= rx_sh;
    end
  end

  assign i2c_tx_active_op = (state != IDLE);
  assign scl_op = scl_low_q ? 1'b0 : 1'bz;
  assign sda_io = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_infc.sv
// tb_i2c_infc: bus-level check of i2c_infc against a byte-list model.
// A passive monitor decodes START/STOP and 9-bit frames from the pulled-up
// lines and also acts as the slave (ACK per mask, read data drive).
module tb_i2c_infc;
  localparam int Q = 4;
  localparam logic [6:0] ADDR = 7'h48;
  localparam int EV_START = 'h400;
  localparam int EV_STOP  = 'h800;

  logic clk, rst, enb, rw_i, act;
  logic [7:0] reg_i, wd_i, rd;
  wire scl_w, sda_w;
  logic slv_low;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = slv_low ? 1'b0 : 1'bz;

  i2c_infc #(.SLAVE_ADDR(ADDR), .QTR_DIV(Q)) dut (
    .clk_ip(clk), .rst_ip(rst), .i2c_enb_ip(enb), .i2c_rw_ip(rw_i),
    .i2c_reg_adr_ip(reg_i), .i2c_wdata_ip(wd_i), .i2c_rd_data_op(rd),
    .scl_op(scl_w), .sda_io(sda_w), .i2c_tx_active_op(act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  int evq[$];
  int expq[$];
  logic [7:0] model_rd;

  // slave / monitor state
  logic [2:0] slv_mask;
  logic [7:0] slv_rdb;
  logic clr_tog = 1'b0, clr_p = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  int bit_idx = 0, frame_cnt = 0, seg_frame = 0;
  logic rd_mode = 1'b0, ackb = 1'b0, have_rise = 1'b0, have_fall = 1'b0;
  logic [7:0] sh = 8'h00;
  int tviol = 0, nphase = 0;
  longint t_edge = 0;

  initial slv_low = 1'b0;

  always @(scl_w or sda_w or clr_tog) begin
    if (clr_tog != clr_p) begin
      clr_p = clr_tog; evq.delete(); bit_idx = 0; frame_cnt = 0; seg_frame = 0;
      rd_mode = 0; slv_low = 0; have_rise = 0; have_fall = 0; tviol = 0; nphase = 0;
    end else if (scl_w !== scl_p) begin
      if (scl_w) begin
        if (have_fall && !rst) begin
          nphase++;
          if ($time - t_edge != 2 * Q * 10) tviol++;
        end
        have_rise = 1; t_edge = $time;
        if (bit_idx < 8) sh = {sh[6:0], sda_w}; else ackb = sda_w;
        bit_idx++;
        if (bit_idx == 9) evq.push_back(int'({ackb, sh}));
      end else begin
        if (have_rise && !rst) begin
          nphase++;
          if ($time - t_edge != 2 * Q * 10) tviol++;
        end
        have_fall = 1; t_edge = $time;
        if (bit_idx == 8) begin
          slv_low = !rd_mode && frame_cnt < 3 && slv_mask[frame_cnt];
        end else if (bit_idx == 9) begin
          bit_idx = 0; frame_cnt++;
          if (rd_mode) rd_mode = 0;
          else if (slv_low && seg_frame == 0 && sh[0]) rd_mode = 1;
          seg_frame++;
          slv_low = rd_mode && !slv_rdb[7];
        end else if (rd_mode && bit_idx < 8) begin
          slv_low = !slv_rdb[7 - bit_idx];
        end
      end
    end else if (sda_w !== sda_p && scl_w) begin
      if (!sda_w) evq.push_back(EV_START);
      else begin evq.push_back(EV_STOP); have_rise = 0; have_fall = 0; end
      bit_idx = 0; seg_frame = 0; rd_mode = 0;
    end
    scl_p = scl_w; sda_p = sda_w;
  end

  task automatic chk(input string nm, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Expected bus events from the transaction description alone.
  task automatic build_exp(input logic rw, input logic [7:0] ra, wd, rdb,
                           input logic [2:0] mask);
    logic [7:0] b [3];
    expq.delete();
    expq.push_back(EV_START);
    b[0] = {ADDR, 1'b0}; b[1] = ra; b[2] = rw ? {ADDR, 1'b1} : wd;
    for (int i = 0; i < 3; i++) begin
      if (i == 2 && rw) expq.push_back(EV_START);
      expq.push_back(int'({~mask[i], b[i]}));
      if (!mask[i]) break;
      if (i == 2 && rw) begin
        expq.push_back(int'({1'b1, rdb}));
        model_rd = rdb;
      end
    end
    expq.push_back(EV_STOP);
  endtask

  task automatic run_txn(input string nm, input logic rw, input logic [7:0] ra, wd, rdb,
                         input logic [2:0] mask, input logic [7:0] exp_rd, input int intr_at);
    int n;
    slv_mask = mask; slv_rdb = rdb;
    clr_tog = ~clr_tog;
    @(negedge clk);
    rst = 1'b0; enb = 1'b1; rw_i = rw; reg_i = ra; wd_i = wd;
    @(negedge clk);
    enb = 1'b0;
    chk({nm, " active"}, int'(act), 1);
    n = 0;
    while (act && n < 5000) begin
      @(negedge clk); n++;
      if (n == intr_at) begin enb = 1'b1; rw_i = ~rw; reg_i = ~ra; wd_i = ~wd; end
      else enb = 1'b0;
    end
    chk({nm, " done"}, int'(act), 0);
    repeat (4) @(negedge clk);
    chk({nm, " nevents"}, evq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s ev%0d", nm, i), (i < evq.size()) ? evq[i] : -1, expq[i]);
    chk({nm, " rd_data"}, int'(rd), int'(exp_rd));
    chk({nm, " scl_timing"}, tviol, 0);
    chk({nm, " phases_seen"}, int'(nphase > 10), 1);
  endtask

  typedef struct {
    logic rw; logic [7:0] ra, wd, rdb; logic [2:0] mask; logic [7:0] exp_rd;
  } vec_t;
  vec_t vt [7];

  initial begin
    int n;
    logic r; logic [7:0] a, d, x; logic [2:0] m;
    vt[0] = '{1'b0, 8'h21, 8'hF6, 8'h00, 3'b111, 8'h00}; // plain write
    vt[1] = '{1'b1, 8'hAB, 8'h00, 8'hFF, 3'b111, 8'hFF}; // read, bus pulled up
    vt[2] = '{1'b1, 8'h3C, 8'h00, 8'h5A, 3'b110, 8'hFF}; // addr NACK
    vt[3] = '{1'b0, 8'h10, 8'h77, 8'h00, 3'b101, 8'hFF}; // reg byte NACK
    vt[4] = '{1'b1, 8'h02, 8'h00, 8'hA5, 3'b111, 8'hA5}; // read 0xA5
    vt[5] = '{1'b1, 8'h40, 8'h00, 8'h0F, 3'b011, 8'hA5}; // addr+R NACK
    vt[6] = '{1'b0, 8'h81, 8'h00, 8'h00, 3'b011, 8'hA5}; // data byte NACK

    rst = 1'b1; enb = 1'b0; rw_i = 1'b0; reg_i = 8'h00; wd_i = 8'h00;
    slv_mask = 3'b111; slv_rdb = 8'hFF; model_rd = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset scl", int'(scl_w), 1);
    chk("reset sda", int'(sda_w), 1);
    chk("reset active", int'(act), 0);
    chk("reset rd_data", int'(rd), 0);

    // first transaction starts in the first cycle after reset release
    for (int i = 0; i < 7; i++) begin
      build_exp(vt[i].rw, vt[i].ra, vt[i].wd, vt[i].rdb, vt[i].mask);
      run_txn($sformatf("vec%0d", i), vt[i].rw, vt[i].ra, vt[i].wd, vt[i].rdb,
              vt[i].mask, vt[i].exp_rd, -1);
    end

    // second enb mid-write must be ignored
    build_exp(1'b0, 8'h5E, 8'h3C, 8'h00, 3'b111);
    run_txn("ignore_enb", 1'b0, 8'h5E, 8'h3C, 8'h00, 3'b111, model_rd, 150);

    // reset during the data byte
    slv_mask = 3'b111; clr_tog = ~clr_tog;
    @(negedge clk); enb = 1'b1; rw_i = 1'b0; reg_i = 8'h44; wd_i = 8'h99;
    @(negedge clk); enb = 1'b0;
    n = 0;
    while (evq.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    chk("rst_reach_data", int'(evq.size() >= 3), 1);
    repeat (6 * Q) @(negedge clk);
    chk("rst_pre_active", int'(act), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async scl", int'(scl_w), 1);
    chk("rst_async sda", int'(sda_w), 1);
    chk("rst_async active", int'(act), 0);
    chk("rst_async rd_data", int'(rd), 0);
    model_rd = 8'h00;
    build_exp(1'b0, 8'h12, 8'h34, 8'h00, 3'b111);
    run_txn("rst_recover", 1'b0, 8'h12, 8'h34, 8'h00, 3'b111, model_rd, -1);

    // randomized transactions against the model
    for (int k = 0; k < 10; k++) begin
      r = 1'($urandom_range(0, 1));
      a = 8'($urandom); d = 8'($urandom); x = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      build_exp(r, a, d, x, m);
      run_txn($sformatf("rand%0d", k), r, a, d, x, m, model_rd, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/i2c_infc.md
I2C_INFC -- requirements
Module: i2c_infc

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h48: 7-bit I2C slave address.
REQ-002 SHALL have parameter QTR_DIV, default 250: clk_ip cycles per SCL quarter-period (100 kHz SCL at 100 MHz).
REQ-003 clk_ip  input  1  system clock; all logic on rising edge.
REQ-004 rst_ip  input  1  reset; one clock, asynchronous and active-high.
REQ-005 i2c_enb_ip  input  1  one-cycle start-transaction pulse.
REQ-006 i2c_rw_ip  input  1  1 = register read, 0 = register write.
REQ-007 i2c_reg_adr_ip  input  8  target register address.
REQ-008 i2c_wdata_ip  input  8  write data.
REQ-009 i2c_rd_data_op  output  8  last byte read from slave.
REQ-010 scl_op  output  1  open-drain SCL: drives 0 or Z, never 1.
REQ-011 sda_io  inout  1  open-drain SDA: drives 0 or Z, never 1.
REQ-012 i2c_tx_active_op  output  1  high while a transaction is in progress.

Function
REQ-013 SHALL register rw, reg_adr and wdata when i2c_enb_ip=1 in IDLE, then assert i2c_tx_active_op on the next cycle.
REQ-014 SHALL ignore i2c_enb_ip while i2c_tx_active_op=1.
REQ-015 SHALL implement states IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_NACK, STOP, all timed in QTR_DIV-cycle quarters.
REQ-016 IDLE: SCL and SDA released.
REQ-017 START: SDA pulled low while SCL released, held 2 quarters, then SCL pulled low.
REQ-018 Data bit: SDA changes only in quarter 0 with SCL low; SCL released in quarters 1-2 and pulled low in quarter 3; read bits and ACK sampled at the end of quarter 2.
REQ-019 Bytes SHALL be sent MSB first.
REQ-020 Write sequence: START, {SLAVE_ADDR,0}, ACK, reg_adr, ACK, wdata, ACK, STOP.
REQ-021 Read sequence: START, {SLAVE_ADDR,0}, ACK, reg_adr, ACK, RSTART, {SLAVE_ADDR,1}, ACK, 8 bits received, master NACK (SDA released), STOP.
REQ-022 RSTART: release SDA with SCL low, release SCL, then pull SDA low after 1 quarter and SCL low after a further quarter.
REQ-023 GET_ACK: release SDA for one bit time; sampled 0 = ACK, continue; sampled 1 = NACK, go to STOP and leave i2c_rd_data_op unchanged.
REQ-024 STOP: SDA low with SCL low, release SCL, after 2 quarters release SDA, then return to IDLE.
REQ-025 i2c_rd_data_op SHALL update only after the 8th received bit of a successful read, and hold otherwise.
REQ-026 i2c_tx_active_op SHALL deassert on the cycle the STOP completes and the state returns to IDLE.
REQ-027 Bit and quarter counters SHALL reset at each byte and each state entry.
REQ-028 There SHALL be no clock stretching; the SCL input is not monitored.

Reset
REQ-029 While rst_ip=1: state IDLE, SCL/SDA released, i2c_tx_active_op=0, i2c_rd_data_op=8'h00, counters and latched inputs cleared.
REQ-030 Reset asserted mid-transaction SHALL release both lines immediately, with no STOP generated.
REQ-031 i2c_enb_ip in the first cycle after reset release SHALL be accepted.

Verification
REQ-032 Write: reg 0x21, data 0xF6, enb pulse, slave ACKs every byte -> bus shows START, 0x90, 0x21, 0xF6, STOP; active high throughout, then low.
REQ-033 Read: reg 0xAB, rw=1, slave ACKs address bytes and leaves SDA pulled up for data -> bus shows 0x90, 0xAB, repeated START, 0x91, master NACK, STOP; i2c_rd_data_op=8'hFF.
REQ-034 Slave NACKs the address byte -> immediate STOP, no further bytes, i2c_rd_data_op unchanged.
REQ-035 Second enb pulse mid-write with different reg/data -> ignored; bus bytes unchanged.
REQ-036 rst_ip asserted during the data byte -> SCL/SDA read 1 (pulled up) and active=0 asynchronously; a new enb after reset release completes normally.
REQ-037 SCL high and low times each equal 2*QTR_DIV clocks; SDA never changes while SCL is high except for START, RSTART and STOP.
